// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the RF write port between pipeline WB (A) and long-latency WB (B) with a busy scoreboard; WB_BYPASS_EN adds decode forwarding
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_stall,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        iss_en,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
`ifdef WB_BYPASS_EN
  input  logic [31:0] rs1_rdata,
  input  logic [31:0] rs2_rdata,
  output logic [31:0] rs1_fwd,
  output logic [31:0] rs2_fwd,
`endif
  output logic        hazard,
  output logic        waw,
  output logic        rf_wb_en,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wb_data
);
  typedef enum logic {NORM, FORCE} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic grant_a, grant_b, starve;
  logic [31:0] busy, busy_nxt, set_v, clr_v;
  // Arbitration: A has priority unless B has been starved into a one-cycle FORCE window
  always_comb begin
    grant_b = (state == FORCE) ? b_valid : (b_valid & ~a_valid);
    grant_a = (state == FORCE) ? (a_valid & ~b_valid) : a_valid;
    starve = b_valid & ~grant_b & (cnt == CNT_W'(STARVE_LIMIT - 1));
    cnt_nxt = (b_valid & ~grant_b & ~starve) ? cnt + 1'b1 : '0;
    state_nxt = starve ? FORCE : NORM;
    b_ready = grant_b;
    a_stall = a_valid & ~grant_a;
  end
  // Scoreboard update: a same-cycle issue to the index being retired keeps it busy
  always_comb begin
    set_v = 32'(iss_en & (|iss_rd)) << iss_rd;
    clr_v = 32'(grant_b) << b_rd;
    busy_nxt = ((busy & ~clr_v) | set_v) & ~32'd1;
    hazard = busy[chk_rs1] | busy[chk_rs2];
    waw = iss_en & busy[iss_rd];
  end
  // FSM state, starvation counter and scoreboard registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= NORM;
      cnt <= '0;
      busy <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      busy <= busy_nxt;
    end
  end
  // Registered write port; writes to x0 complete the handshake but never reach the RF
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wb_en <= 1'b0;
      rf_rd <= '0;
      rf_wb_data <= '0;
    end else begin
      rf_wb_en <= (grant_a & (|a_rd)) | (grant_b & (|b_rd));
      if (grant_a & (|a_rd)) begin
        rf_rd <= a_rd;
        rf_wb_data <= a_data;
      end else if (grant_b & (|b_rd)) begin
        rf_rd <= b_rd;
        rf_wb_data <= b_data;
      end
    end
  end
`ifdef WB_BYPASS_EN
  // Forward the write in flight so decode sees it in the RF write-then-read cycle
  always_comb begin
    rs1_fwd = (rf_wb_en && rf_rd == chk_rs1 && chk_rs1 != 5'd0) ? rf_wb_data : rs1_rdata;
    rs2_fwd = (rf_wb_en && rf_rd == chk_rs2 && chk_rs2 != 5'd0) ? rf_wb_data : rs2_rdata;
  end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic a_valid, b_valid, iss_en;
  logic [4:0] a_rd, b_rd, iss_rd, chk_rs1, chk_rs2;
  logic [31:0] a_data, b_data;
  logic a_stall, b_ready, hazard, waw, rf_wb_en;
  logic [4:0] rf_rd;
  logic [31:0] rf_wb_data;
`ifdef WB_BYPASS_EN
  logic [31:0] rs1_rdata, rs2_rdata, rs1_fwd, rs2_fwd;
`endif
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_stall(a_stall),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .iss_en(iss_en), .iss_rd(iss_rd), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
`ifdef WB_BYPASS_EN
    .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata), .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
`endif
    .hazard(hazard), .waw(waw),
    .rf_wb_en(rf_wb_en), .rf_rd(rf_rd), .rf_wb_data(rf_wb_data)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    a_valid = 0; b_valid = 0; iss_en = 0;
    a_rd = 0; b_rd = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
    a_data = 0; b_data = 0;
  endtask
  task automatic test_reset();
    rst = 0;
    idle();
    #12;
    tests++; if (rf_wb_en !== 1'b0) begin fails++; $display("FAIL reset_en got %b exp 0", rf_wb_en); end
    tests++; if (rf_rd !== 5'd0) begin fails++; $display("FAIL reset_rd got %0d exp 0", rf_rd); end
    tests++; if (rf_wb_data !== 32'd0) begin fails++; $display("FAIL reset_data got %h exp 0", rf_wb_data); end
    tests++; if ({hazard, waw, b_ready, a_stall} !== 4'b0) begin fails++; $display("FAIL reset_comb got %b exp 0000", {hazard, waw, b_ready, a_stall}); end
    rst = 1;
    tick();
  endtask
  task automatic test_a_only();
    a_valid = 1; a_rd = 5; a_data = 32'h11;
    #1;
    tests++; if (a_stall !== 1'b0) begin fails++; $display("FAIL a_only_stall got %b exp 0", a_stall); end
    tick();
    idle();
    tests++; if ({rf_wb_en, rf_rd} !== {1'b1, 5'd5}) begin fails++; $display("FAIL a_only_wb got en=%b rd=%0d exp en=1 rd=5", rf_wb_en, rf_rd); end
    tests++; if (rf_wb_data !== 32'h11) begin fails++; $display("FAIL a_only_data got %h exp 11", rf_wb_data); end
    tick();
    tests++; if (rf_wb_en !== 1'b0) begin fails++; $display("FAIL a_only_idle_en got %b exp 0", rf_wb_en); end
  endtask
  task automatic test_starvation();
    a_valid = 1; a_rd = 1; a_data = 32'h22;
    b_valid = 1; b_rd = 2; b_data = 32'h33;
    for (int c = 1; c <= 6; c++) begin
      #1;
      tests++; if ({b_ready, a_stall} !== {2{c == 5}}) begin fails++; $display("FAIL starve_c%0d got b_ready=%b a_stall=%b exp %b", c, b_ready, a_stall, c == 5); end
      tick();
      if (c == 5) begin
        tests++; if ({rf_wb_en, rf_rd, rf_wb_data} !== {1'b1, 5'd2, 32'h33}) begin fails++; $display("FAIL starve_bwrite got en=%b rd=%0d data=%h exp 1 2 33", rf_wb_en, rf_rd, rf_wb_data); end
      end
      if (c == 6) begin
        tests++; if ({rf_rd, rf_wb_data} !== {5'd1, 32'h22}) begin fails++; $display("FAIL starve_awrite got rd=%0d data=%h exp 1 22", rf_rd, rf_wb_data); end
      end
    end
    idle();
    tick();
  endtask
  task automatic test_scoreboard();
    iss_en = 1; iss_rd = 7; chk_rs1 = 7;
    #1;
    tests++; if ({hazard, waw} !== 2'b00) begin fails++; $display("FAIL sb_same_cycle got hazard=%b waw=%b exp 00", hazard, waw); end
    tick();
    iss_en = 0; iss_rd = 0;
    #1;
    tests++; if (hazard !== 1'b1) begin fails++; $display("FAIL sb_hazard got %b exp 1", hazard); end
    b_valid = 1; b_rd = 7; b_data = 32'h77;
    #1;
    tests++; if (b_ready !== 1'b1) begin fails++; $display("FAIL sb_b_ready got %b exp 1", b_ready); end
    tick();
    b_valid = 0;
    #1;
    tests++; if (hazard !== 1'b0) begin fails++; $display("FAIL sb_cleared got %b exp 0", hazard); end
    idle();
  endtask
  task automatic test_set_wins();
    iss_en = 1; iss_rd = 9;
    tick();
    b_valid = 1; b_rd = 9; b_data = 32'h99;
    #1;
    tests++; if ({waw, b_ready} !== 2'b11) begin fails++; $display("FAIL setwin_waw got waw=%b b_ready=%b exp 11", waw, b_ready); end
    tick();
    b_valid = 0; iss_rd = 0; chk_rs2 = 9;
    #1;
    tests++; if ({hazard, waw} !== 2'b10) begin fails++; $display("FAIL setwin_busy got hazard=%b waw=%b exp 10", hazard, waw); end
    tick();
    iss_en = 0;
    #1;
    tests++; if (hazard !== 1'b1) begin fails++; $display("FAIL setwin_rd0_unchanged got %b exp 1", hazard); end
    chk_rs2 = 0;
    #1;
    tests++; if (hazard !== 1'b0) begin fails++; $display("FAIL setwin_idx0 got %b exp 0", hazard); end
    b_valid = 1; b_rd = 9;
    tick();
    idle();
    chk_rs1 = 9;
    #1;
    tests++; if (hazard !== 1'b0) begin fails++; $display("FAIL setwin_clear got %b exp 0", hazard); end
    idle();
  endtask
  task automatic test_rd_zero();
    b_valid = 1; b_rd = 0; b_data = 32'hDEAD;
    #1;
    tests++; if (b_ready !== 1'b1) begin fails++; $display("FAIL rd0_b_ready got %b exp 1", b_ready); end
    tick();
    idle();
    tests++; if (rf_wb_en !== 1'b0) begin fails++; $display("FAIL rd0_b_en got %b exp 0", rf_wb_en); end
    a_valid = 1; a_rd = 0; a_data = 32'hBEEF;
    #1;
    tests++; if (a_stall !== 1'b0) begin fails++; $display("FAIL rd0_a_stall got %b exp 0", a_stall); end
    tick();
    idle();
    tests++; if (rf_wb_en !== 1'b0) begin fails++; $display("FAIL rd0_a_en got %b exp 0", rf_wb_en); end
  endtask
  task automatic test_reset_mid();
    iss_en = 1; iss_rd = 4; chk_rs1 = 4;
    a_valid = 1; a_rd = 3; a_data = 32'h44;
    b_valid = 1; b_rd = 6; b_data = 32'h66;
    tick();
    iss_en = 0; iss_rd = 0;
    tick();
    tick();
    #2;
    rst = 0;
    #1;
    tests++; if ({rf_wb_en, rf_rd, rf_wb_data} !== 38'd0) begin fails++; $display("FAIL rstmid_regs got en=%b rd=%0d data=%h exp 0", rf_wb_en, rf_rd, rf_wb_data); end
    tests++; if (hazard !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b exp 0", hazard); end
    rst = 1;
    for (int c = 1; c <= 5; c++) begin
      tests++; if (b_ready !== (c == 5)) begin fails++; $display("FAIL rstmid_cnt_c%0d got b_ready=%b exp %b", c, b_ready, c == 5); end
      tick();
    end
    idle();
    tick();
  endtask
`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    a_valid = 1; a_rd = 3; a_data = 32'hAB;
    tick();
    idle();
    rs1_rdata = 32'h1111; rs2_rdata = 32'h5555;
    chk_rs1 = 5; chk_rs2 = 3;
    #1;
    tests++; if (rs2_fwd !== 32'hAB) begin fails++; $display("FAIL bypass_fwd got %h exp ab", rs2_fwd); end
    tests++; if (rs1_fwd !== 32'h1111) begin fails++; $display("FAIL bypass_nomatch got %h exp 1111", rs1_fwd); end
    chk_rs2 = 0;
    #1;
    tests++; if (rs2_fwd !== 32'h5555) begin fails++; $display("FAIL bypass_idx0 got %h exp 5555", rs2_fwd); end
    tick();
    chk_rs2 = 3;
    #1;
    tests++; if (rs2_fwd !== 32'h5555) begin fails++; $display("FAIL bypass_stale got %h exp 5555", rs2_fwd); end
    idle();
  endtask
`endif
  initial begin
`ifdef WB_BYPASS_EN
    rs1_rdata = 0; rs2_rdata = 0;
`endif
    test_reset();
    test_a_only();
    test_starvation();
    test_scoreboard();
    test_set_wins();
    test_rd_zero();
    test_reset_mid();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
